// File: rtl/adc_sched.sv
// ADC conversion scheduler: round-robin arbitration of four requesters onto one
// SPI ADC engine, with background polling of both channels and a per-conversion timeout.
module adc_sched #(
   parameter int POLL_DIV = 1024,
   parameter int TIMEOUT  = 255,
   parameter int DATA_W   = 12
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [3:0]        req,
   input  logic [3:0]        req_ch,
   output logic [3:0]        ack,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_err,
   output logic              conv_start,
   output logic              conv_ch,
   input  logic              conv_busy,
   input  logic              conv_done,
   input  logic [DATA_W-1:0] conv_data,
   output logic [DATA_W-1:0] ain0,
   output logic [DATA_W-1:0] ain1,
   output logic              fault
);

   localparam int PW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, START, WAIT, ACK} state_t;

   state_t          state, state_nxt;
   logic [1:0]      last_grant;
   logic [1:0]      grant_idx;
   logic            src_req;
   logic [TW-1:0]   tmo_cnt;
   logic [PW-1:0]   poll_cnt;
   logic            poll_pend;
   logic            poll_ch;

   logic            arb_found;
   logic [1:0]      arb_idx;
   logic            grant_en;
   logic            poll_launch;
   logic            wait_done;
   logic            wait_tmo;
   logic            tmo_last;
   logic            poll_wrap;

   // Round-robin: first requester found scanning upward from last_grant+1.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = last_grant;
      for (int i = 1; i <= 4; i++) begin
         if (!arb_found && req[last_grant + 2'(i)]) begin
            arb_found = 1'b1;
            arb_idx   = last_grant + 2'(i);
         end
      end
   end

   // Expiry is flagged in the last permitted WAIT cycle so at most TIMEOUT cycles are spent there.
   assign tmo_last  = (TIMEOUT <= 1) || (tmo_cnt == TW'(TIMEOUT - 1));
   assign poll_wrap = (POLL_DIV != 0) && (poll_cnt == PW'(POLL_DIV - 1));

   always_comb begin
      state_nxt   = state;
      grant_en    = 1'b0;
      poll_launch = 1'b0;
      wait_done   = 1'b0;
      wait_tmo    = 1'b0;
      case (state)
         IDLE: begin
            if (!conv_busy) begin
               if (arb_found) begin
                  grant_en  = 1'b1;
                  state_nxt = START;
               end else if (poll_pend) begin
                  poll_launch = 1'b1;
                  state_nxt   = START;
               end
            end
         end
         START: state_nxt = WAIT;
         WAIT: begin
            if (conv_done) begin
               wait_done = 1'b1;
               state_nxt = ACK;
            end else if (tmo_last) begin
               wait_tmo  = 1'b1;
               state_nxt = ACK;
            end
         end
         ACK: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign conv_start = (state == START);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= 2'd3;
         grant_idx  <= 2'd0;
         src_req    <= 1'b0;
         conv_ch    <= 1'b0;
         tmo_cnt    <= '0;
      end else begin
         state <= state_nxt;
         if (grant_en) begin
            grant_idx  <= arb_idx;
            last_grant <= arb_idx;
            src_req    <= 1'b1;
            conv_ch    <= req_ch[arb_idx];
         end else if (poll_launch) begin
            src_req <= 1'b0;
            conv_ch <= poll_ch;
         end
         if (state == START)
            tmo_cnt <= '0;
         else if (state == WAIT)
            tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   // Result, ack and channel mirrors are loaded on the WAIT exit edge and are visible during ACK.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ack     <= 4'b0000;
         rd_data <= '0;
         rd_err  <= 1'b0;
         ain0    <= '0;
         ain1    <= '0;
         fault   <= 1'b0;
      end else begin
         ack <= 4'b0000;
         if (wait_done || wait_tmo) begin
            if (src_req && req[grant_idx])
               ack <= 4'b0001 << grant_idx;
            rd_data <= wait_done ? conv_data : '0;
            rd_err  <= wait_tmo;
         end
         if (wait_done) begin
            if (conv_ch)
               ain1 <= conv_data;
            else
               ain0 <= conv_data;
         end
         if (wait_tmo)
            fault <= 1'b1;
      end
   end

   // A wrap while a poll is still pending is absorbed, not queued.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         poll_cnt  <= '0;
         poll_pend <= 1'b0;
         poll_ch   <= 1'b0;
      end else begin
         if (poll_wrap || (POLL_DIV == 0))
            poll_cnt <= '0;
         else
            poll_cnt <= poll_cnt + 1'b1;
         if (poll_wrap)
            poll_pend <= 1'b1;
         else if (poll_launch)
            poll_pend <= 1'b0;
         if (poll_launch)
            poll_ch <= ~poll_ch;
      end
   end

endmodule

// File: tb/tb_adc_sched.sv
// Directed bench for adc_sched: a request-driven instance with polling disabled and a
// poll-only instance, each fed by a small behavioural ADC engine.
module tb_adc_sched;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        reset_b = 1'b1;

   logic [3:0]  req = 4'b0000, req_ch = 4'b0000;
   logic [3:0]  ack;
   logic [11:0] rd_data, conv_data, ain0, ain1;
   logic        rd_err, conv_start, conv_ch, fault;
   logic        conv_busy = 1'b0, conv_done = 1'b0;

   logic [3:0]  ack_b;
   logic [11:0] rd_data_b, conv_data_b, ain0_b, ain1_b;
   logic        rd_err_b, conv_start_b, conv_ch_b, fault_b;
   logic        conv_busy_b = 1'b0, conv_done_b = 1'b0;

   int          n_chk = 0, n_pass = 0;
   int          eng_delay = 40, eng_left = 0;
   bit          eng_mute = 1'b0;
   logic [11:0] eng_data = 12'h000;
   int          left_b = 0;
   logic [11:0] n_b = 12'h000;
   bit          ack_b_seen = 1'b0;

   always #5 clock = ~clock;

   adc_sched #(.POLL_DIV(0), .TIMEOUT(255), .DATA_W(12)) dut (
      .clock(clock), .reset(reset), .req(req), .req_ch(req_ch), .ack(ack),
      .rd_data(rd_data), .rd_err(rd_err), .conv_start(conv_start), .conv_ch(conv_ch),
      .conv_busy(conv_busy), .conv_done(conv_done), .conv_data(conv_data),
      .ain0(ain0), .ain1(ain1), .fault(fault)
   );

   adc_sched #(.POLL_DIV(100), .TIMEOUT(255), .DATA_W(12)) dut_poll (
      .clock(clock), .reset(reset_b), .req(4'b0000), .req_ch(4'b0000), .ack(ack_b),
      .rd_data(rd_data_b), .rd_err(rd_err_b), .conv_start(conv_start_b), .conv_ch(conv_ch_b),
      .conv_busy(conv_busy_b), .conv_done(conv_done_b), .conv_data(conv_data_b),
      .ain0(ain0_b), .ain1(ain1_b), .fault(fault_b)
   );

   // Engine A: result captured at start, done pulse eng_delay cycles later (unless muted).
   initial begin
      conv_data = 12'h000;
      forever begin
         @(negedge clock);
         conv_done = 1'b0;
         if (eng_left > 0) begin
            eng_left--;
            if (eng_left == 0) begin
               conv_busy = 1'b0;
               if (!eng_mute) conv_done = 1'b1;
            end
         end
         if (conv_start) begin
            eng_left  = eng_delay;
            conv_busy = 1'b1;
            conv_data = eng_data;
         end
      end
   end

   // Engine B: fixed 5-cycle conversions, result tagged with channel and sequence number.
   initial begin
      conv_data_b = 12'h000;
      forever begin
         @(negedge clock);
         conv_done_b = 1'b0;
         if (ack_b != 4'b0000) ack_b_seen = 1'b1;
         if (left_b > 0) begin
            left_b--;
            if (left_b == 0) begin
               conv_busy_b = 1'b0;
               conv_done_b = 1'b1;
            end
         end
         if (conv_start_b) begin
            left_b      = 5;
            conv_busy_b = 1'b1;
            conv_data_b = conv_ch_b ? (12'hC00 | n_b) : (12'h300 | n_b);
            n_b++;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic wait_ack(input int max, output int cyc, output logic [3:0] seen);
      cyc  = 0;
      seen = 4'b0000;
      while (cyc < max) begin
         @(negedge clock);
         cyc++;
         if (ack != 4'b0000) begin
            seen = ack;
            break;
         end
      end
   endtask

   task automatic wait_start(input int max, output int cyc);
      cyc = 0;
      while (cyc < max) begin
         @(negedge clock);
         cyc++;
         if (conv_start) break;
      end
      if (!conv_start) cyc = -1;
   endtask

   task automatic wait_start_b(input int max, output int cyc);
      cyc = 0;
      while (cyc < max) begin
         @(negedge clock);
         cyc++;
         if (conv_start_b) break;
      end
      if (!conv_start_b) cyc = -1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ack"}, 32'(ack), 32'h0);
      chk({tag, "_conv_start"}, 32'(conv_start), 32'h0);
      chk({tag, "_conv_ch"}, 32'(conv_ch), 32'h0);
      chk({tag, "_rd_data"}, 32'(rd_data), 32'h0);
      chk({tag, "_rd_err"}, 32'(rd_err), 32'h0);
      chk({tag, "_ain0"}, 32'(ain0), 32'h0);
      chk({tag, "_ain1"}, 32'(ain1), 32'h0);
      chk({tag, "_fault"}, 32'(fault), 32'h0);
   endtask

   initial begin
      int          cyc;
      logic [3:0]  seen;
      logic [3:0]  exp_ord [5];
      exp_ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

      // Reset state
      repeat (3) @(negedge clock);
      chk_all_zero("rst");
      reset = 1'b0;

      // Single request, channel 1, result 0xABC after 40 cycles
      @(negedge clock);
      eng_delay = 40; eng_data = 12'hABC;
      req = 4'b0001; req_ch = 4'b0001;
      chk("t1_no_start_yet", 32'(conv_start), 32'h0);
      @(negedge clock);
      chk("t1_start_lat", 32'(conv_start), 32'h1);
      chk("t1_conv_ch", 32'(conv_ch), 32'h1);
      wait_ack(100, cyc, seen);
      req = 4'b0000;
      chk("t1_ack_lat", 32'(cyc), 32'd41);
      chk("t1_ack", 32'(seen), 32'b0001);
      chk("t1_rd_data", 32'(rd_data), 32'hABC);
      chk("t1_rd_err", 32'(rd_err), 32'h0);
      chk("t1_ain1", 32'(ain1), 32'hABC);

      // Timeout: engine silent, requester 1 on channel 1
      @(negedge clock);
      eng_mute = 1'b1;
      req = 4'b0010; req_ch = 4'b0010;
      wait_start(10, cyc);
      wait_ack(400, cyc, seen);
      req = 4'b0000;
      chk("t2_ack_lat", 32'(cyc), 32'd256);
      chk("t2_ack", 32'(seen), 32'b0010);
      chk("t2_rd_err", 32'(rd_err), 32'h1);
      chk("t2_rd_data", 32'(rd_data), 32'h0);
      chk("t2_fault", 32'(fault), 32'h1);
      chk("t2_ain1_kept", 32'(ain1), 32'hABC);
      @(negedge clock);
      eng_mute = 1'b0;

      // Requester 2 drops during WAIT: no ack, channel 0 still updated
      eng_delay = 20; eng_data = 12'h5A5;
      req = 4'b0100; req_ch = 4'b0000;
      wait_start(10, cyc);
      repeat (5) @(negedge clock);
      req = 4'b0000;
      wait_ack(40, cyc, seen);
      chk("t3_no_ack", 32'(seen), 32'h0);
      chk("t3_ain0", 32'(ain0), 32'h5A5);
      chk("t3_fault_sticky", 32'(fault), 32'h1);

      // All four requesting from reset: round-robin order 0,1,2,3,0
      reset = 1'b1;
      eng_delay = 10; eng_data = 12'h3C3;
      req = 4'b1111; req_ch = 4'b1010;
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         wait_ack(100, cyc, seen);
         chk($sformatf("t4_ack%0d", i), 32'(seen), 32'(exp_ord[i]));
         chk($sformatf("t4_onehot%0d", i), 32'($countones(seen)), 32'd1);
         chk($sformatf("t4_rd_data%0d", i), 32'(rd_data), 32'h3C3);
      end
      req = 4'b0000;
      chk("t4_ain1", 32'(ain1), 32'h3C3);
      repeat (3) @(negedge clock);

      // Reset in WAIT, late conv_done ignored, requester 0 wins afterwards
      eng_delay = 30; eng_data = 12'h777;
      req = 4'b0010; req_ch = 4'b0010;
      wait_start(10, cyc);
      repeat (5) @(negedge clock);
      reset = 1'b1;
      #1;
      chk_all_zero("t5_rst");
      req = 4'b0000;
      @(negedge clock);
      reset = 1'b0;
      eng_data = 12'h246;
      req = 4'b1111; req_ch = 4'b0000;
      wait_ack(100, cyc, seen);
      req = 4'b0000;
      chk("t5_ack", 32'(seen), 32'b0001);
      chk("t5_rd_data", 32'(rd_data), 32'h246);
      chk("t5_ain0", 32'(ain0), 32'h246);
      chk("t5_ain1_ignored", 32'(ain1), 32'h0);

      // Background polling every 100 cycles, alternating channels
      reset_b = 1'b0;
      wait_start_b(300, cyc);
      chk("t6_first_ch", 32'(conv_ch_b), 32'h0);
      wait_start_b(300, cyc);
      chk("t6_period1", 32'(cyc), 32'd100);
      chk("t6_second_ch", 32'(conv_ch_b), 32'h1);
      chk("t6_ain0", 32'(ain0_b), 32'h300);
      wait_start_b(300, cyc);
      chk("t6_period2", 32'(cyc), 32'd100);
      chk("t6_third_ch", 32'(conv_ch_b), 32'h0);
      chk("t6_ain1", 32'(ain1_b), 32'hC01);
      repeat (10) @(negedge clock);
      chk("t6_ain0_again", 32'(ain0_b), 32'h302);
      chk("t6_no_ack", 32'(ack_b_seen), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
